uart_rx_frame_controller: RTL and testbench

Receive-side frame sequencer for the UART. It oversamples the serial `rx` line and detects and validates the start bit. It shifts in 8 data bits (LSB first) plus one parity bit and applies the team's even-parity check: the XOR of the 8 data bits must equal the parity bit. It then validates the stop bit and hands the byte to the downstream consumer with one-cycle status pulses. It sits between the RX pin and the byte consumer, and is the block that sequences the 9-bit data/parity word into the parity check.

---
 rtl/uart_rx_frame_controller.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_frame_controller.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_controller.sv
// UART receive frame sequencer: start-bit qualification, 8 data bits LSB first,
// even-parity check (XOR of data equals parity bit), stop-bit check and one-cycle status pulses.
module uart_rx_frame_controller #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic [7:0] o_data_out,
    output logic       o_data_valid,
    output logic       o_parity_error,
    output logic       o_framing_error,
    output logic       o_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [2:0]    r_idx, w_idx_next;
    logic [7:0]    r_shift, w_shift_next;
    logic          r_parity, w_parity_next;
    logic          r_stop_seen, w_stop_seen_next;
    logic          r_stop_bit, w_stop_bit_next;
    logic [7:0]    r_data_out, w_data_out_next;
    logic          r_data_valid, w_data_valid_next;
    logic          r_parity_error, w_parity_error_next;
    logic          r_framing_error, w_framing_error_next;
    logic          r_rx_meta, r_rx_s;
    logic          w_tick, w_parity_ok;

    // Synchronizer idles high so a reset never fabricates a start bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_idx           <= '0;
            r_shift         <= '0;
            r_parity        <= 1'b0;
            r_stop_seen     <= 1'b0;
            r_stop_bit      <= 1'b0;
            r_data_out      <= 8'h00;
            r_data_valid    <= 1'b0;
            r_parity_error  <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_cnt           <= w_cnt_next;
            r_idx           <= w_idx_next;
            r_shift         <= w_shift_next;
            r_parity        <= w_parity_next;
            r_stop_seen     <= w_stop_seen_next;
            r_stop_bit      <= w_stop_bit_next;
            r_data_out      <= w_data_out_next;
            r_data_valid    <= w_data_valid_next;
            r_parity_error  <= w_parity_error_next;
            r_framing_error <= w_framing_error_next;
        end
    end

    assign w_tick      = (r_cnt == FULL_M1);
    assign w_parity_ok = ((^r_shift) == r_parity);

    always_comb begin
        w_state_next         = r_state;
        w_cnt_next           = r_cnt + CW'(1);
        w_idx_next           = r_idx;
        w_shift_next         = r_shift;
        w_parity_next        = r_parity;
        w_stop_seen_next     = 1'b0;
        w_stop_bit_next      = r_stop_bit;
        w_data_out_next      = r_data_out;
        w_data_valid_next    = 1'b0;
        w_parity_error_next  = 1'b0;
        w_framing_error_next = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (!r_rx_s) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (r_cnt == HALF_M1) begin
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                    w_state_next = r_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_next[r_idx] = r_rx_s;
                    w_cnt_next          = '0;
                    w_idx_next          = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_parity_next = r_rx_s;
                    w_cnt_next    = '0;
                    w_state_next  = STOP;
                end
            end
            // The stop sample is held one cycle so pulses land on the edge IDLE is re-entered.
            STOP: begin
                if (r_stop_seen) begin
                    w_cnt_next           = '0;
                    w_data_out_next      = w_parity_ok ? r_shift : 8'h00;
                    w_data_valid_next    = w_parity_ok && r_stop_bit;
                    w_parity_error_next  = !w_parity_ok;
                    w_framing_error_next = !r_stop_bit;
                    w_state_next         = r_stop_bit ? IDLE : WAIT_IDLE;
                end else if (w_tick) begin
                    w_cnt_next       = '0;
                    w_stop_bit_next  = r_rx_s;
                    w_stop_seen_next = 1'b1;
                end
            end
            WAIT_IDLE: begin
                w_cnt_next = '0;
                if (r_rx_s) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign o_data_out      = r_data_out;
    assign o_data_valid    = r_data_valid;
    assign o_parity_error  = r_parity_error;
    assign o_framing_error = r_framing_error;
    assign o_busy          = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_controller.sv
// Scoreboard bench for uart_rx_frame_controller: each frame pushes its expected status
// pulse (flags, byte and arrival cycle); a negedge monitor collects what the DUT emits.
module tb_uart_rx_frame_controller;
    localparam int CPB = 16;
    // Pin fall to status pulse: 2 synchronizer edges, 1 detect edge, then E0 + 169.
    localparam int PULSE_LAT = 172;

    typedef struct packed {
        logic        dv;
        logic        pe;
        logic        fe;
        logic [7:0]  data;
        logic [31:0] cyc;
    } ev_t;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] dataOut;
    logic       dataValid;
    logic       parityError;
    logic       framingError;
    logic       busy;

    int  tests = 0;
    int  failed = 0;
    int  cyc = 0;
    ev_t expQ[$];
    ev_t obsQ[$];

    uart_rx_frame_controller #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_rx           (rx),
        .o_data_out     (dataOut),
        .o_data_valid   (dataValid),
        .o_parity_error (parityError),
        .o_framing_error(framingError),
        .o_busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t ev;
        if (dataValid || parityError || framingError) begin
            ev.dv   = dataValid;
            ev.pe   = parityError;
            ev.fe   = framingError;
            ev.data = dataOut;
            ev.cyc  = 32'(cyc);
            obsQ.push_back(ev);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time exhausted, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic holdRx(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; the expected pulse is derived from the byte, parity and stop given.
    task automatic sendFrame(input logic [7:0] d, input logic par, input logic stop);
        ev_t  e;
        logic ok;
        ok     = ((^d) == par);
        e.dv   = ok && stop;
        e.pe   = !ok;
        e.fe   = !stop;
        e.data = ok ? d : 8'h00;
        e.cyc  = 32'(cyc + PULSE_LAT);
        expQ.push_back(e);
        holdRx(1'b0, CPB);
        for (int i = 0; i < 8; i++) holdRx(d[i], CPB);
        holdRx(par, CPB);
        holdRx(stop, CPB);
    endtask

    task automatic waitEvents(input int n);
        int w = 0;
        while (obsQ.size() < n && w < 400) begin
            @(negedge clk);
            w++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({dataOut, dataValid, parityError, framingError, busy} !== 12'h000) begin
            failed++;
            $display("[TB] FAIL reset_outputs: got data=%h dv=%b pe=%b fe=%b busy=%b, want all 0",
                     dataOut, dataValid, parityError, framingError, busy);
        end
        reset = 1'b0;
        repeat (6) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || dataOut !== 8'h00) begin
            failed++;
            $display("[TB] FAIL reset_release: got busy=%b data=%h, want busy=0 data=00", busy, dataOut);
        end
        tests++;
        if (obsQ.size() != 0) begin
            failed++;
            $display("[TB] FAIL reset_pulses: got %0d pulses, want 0", obsQ.size());
            obsQ.delete();
        end
    endtask

    task automatic test_good_frame;
        ev_t o, e;
        sendFrame(8'hA5, 1'b0, 1'b1);
        waitEvents(1);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = '0;
            if (obsQ.size() > 0) o = obsQ.pop_front();
            tests++;
            if (o !== e) begin
                failed++;
                $display("[TB] FAIL good_frame: got dv=%b pe=%b fe=%b data=%h cycle=%0d, want dv=%b pe=%b fe=%b data=%h cycle=%0d",
                         o.dv, o.pe, o.fe, o.data, o.cyc, e.dv, e.pe, e.fe, e.data, e.cyc);
            end
        end
        tests++;
        if (obsQ.size() != 0) begin
            failed++;
            $display("[TB] FAIL good_frame_extra: got %0d extra pulses, want 0", obsQ.size());
            obsQ.delete();
        end
        tests++;
        if (dataOut !== 8'hA5) begin
            failed++;
            $display("[TB] FAIL good_frame_hold: got data=%h, want a5", dataOut);
        end
    endtask

    task automatic test_start_glitch;
        holdRx(1'b0, 3);
        rx = 1'b1;
        repeat (7) @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            failed++;
            $display("[TB] FAIL glitch_busy_before_sample: got busy=%b, want 1", busy);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            failed++;
            $display("[TB] FAIL glitch_busy_after_sample: got busy=%b, want 0", busy);
        end
        repeat (40) @(negedge clk);
        tests++;
        if (obsQ.size() != 0) begin
            failed++;
            $display("[TB] FAIL glitch_pulses: got %0d pulses, want 0", obsQ.size());
            obsQ.delete();
        end
        tests++;
        if (dataOut !== 8'hA5) begin
            failed++;
            $display("[TB] FAIL glitch_data_hold: got data=%h, want a5", dataOut);
        end
    endtask

    task automatic test_parity;
        ev_t o, e;
        sendFrame(8'h07, 1'b1, 1'b1);
        sendFrame(8'hA5, 1'b1, 1'b1);
        waitEvents(2);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = '0;
            if (obsQ.size() > 0) o = obsQ.pop_front();
            tests++;
            if (o !== e) begin
                failed++;
                $display("[TB] FAIL parity_frame: got dv=%b pe=%b fe=%b data=%h cycle=%0d, want dv=%b pe=%b fe=%b data=%h cycle=%0d",
                         o.dv, o.pe, o.fe, o.data, o.cyc, e.dv, e.pe, e.fe, e.data, e.cyc);
            end
        end
        tests++;
        if (obsQ.size() != 0) begin
            failed++;
            $display("[TB] FAIL parity_extra: got %0d extra pulses, want 0", obsQ.size());
            obsQ.delete();
        end
        tests++;
        if (dataOut !== 8'h00) begin
            failed++;
            $display("[TB] FAIL parity_data_hold: got data=%h, want 00", dataOut);
        end
    endtask

    task automatic test_framing_break;
        ev_t  o, e;
        logic busyDropped = 1'b0;
        sendFrame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy !== 1'b1) busyDropped = 1'b1;
        end
        tests++;
        if (busyDropped) begin
            failed++;
            $display("[TB] FAIL break_busy_hold: got busy low while line low, want 1");
        end
        rx = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            failed++;
            $display("[TB] FAIL break_busy_sync: got busy=%b 2 cycles after rise, want 1", busy);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            failed++;
            $display("[TB] FAIL break_busy_release: got busy=%b 3 cycles after rise, want 0", busy);
        end
        waitEvents(1);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = '0;
            if (obsQ.size() > 0) o = obsQ.pop_front();
            tests++;
            if (o !== e) begin
                failed++;
                $display("[TB] FAIL framing_frame: got dv=%b pe=%b fe=%b data=%h cycle=%0d, want dv=%b pe=%b fe=%b data=%h cycle=%0d",
                         o.dv, o.pe, o.fe, o.data, o.cyc, e.dv, e.pe, e.fe, e.data, e.cyc);
            end
        end
        tests++;
        if (obsQ.size() != 0) begin
            failed++;
            $display("[TB] FAIL framing_extra: got %0d extra pulses, want 0", obsQ.size());
            obsQ.delete();
        end
    endtask

    task automatic test_back_to_back;
        ev_t o, e;
        sendFrame(8'h55, 1'b0, 1'b1);
        sendFrame(8'hFF, 1'b0, 1'b1);
        waitEvents(2);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = '0;
            if (obsQ.size() > 0) o = obsQ.pop_front();
            tests++;
            if (o !== e) begin
                failed++;
                $display("[TB] FAIL back_to_back: got dv=%b pe=%b fe=%b data=%h cycle=%0d, want dv=%b pe=%b fe=%b data=%h cycle=%0d",
                         o.dv, o.pe, o.fe, o.data, o.cyc, e.dv, e.pe, e.fe, e.data, e.cyc);
            end
        end
        tests++;
        if (obsQ.size() != 0) begin
            failed++;
            $display("[TB] FAIL back_to_back_extra: got %0d extra pulses, want 0", obsQ.size());
            obsQ.delete();
        end
    endtask

    task automatic test_reset_mid_frame;
        ev_t  o, e;
        logic busySeen = 1'b0;
        holdRx(1'b0, CPB);
        for (int i = 0; i < 4; i++) holdRx(1'b0, CPB);
        holdRx(1'b0, 6);
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge clk);
        tests++;
        if ({dataOut, dataValid, parityError, framingError, busy} !== 12'h000) begin
            failed++;
            $display("[TB] FAIL midframe_reset_outputs: got data=%h dv=%b pe=%b fe=%b busy=%b, want all 0",
                     dataOut, dataValid, parityError, framingError, busy);
        end
        reset = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (busy !== 1'b0) busySeen = 1'b1;
        end
        tests++;
        if (busySeen) begin
            failed++;
            $display("[TB] FAIL midframe_false_start: got busy high after reset, want 0");
        end
        tests++;
        if (obsQ.size() != 0) begin
            failed++;
            $display("[TB] FAIL midframe_pulses: got %0d pulses, want 0", obsQ.size());
            obsQ.delete();
        end
        sendFrame(8'h81, 1'b0, 1'b1);
        waitEvents(1);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = '0;
            if (obsQ.size() > 0) o = obsQ.pop_front();
            tests++;
            if (o !== e) begin
                failed++;
                $display("[TB] FAIL midframe_next_frame: got dv=%b pe=%b fe=%b data=%h cycle=%0d, want dv=%b pe=%b fe=%b data=%h cycle=%0d",
                         o.dv, o.pe, o.fe, o.data, o.cyc, e.dv, e.pe, e.fe, e.data, e.cyc);
            end
        end
        tests++;
        if (obsQ.size() != 0) begin
            failed++;
            $display("[TB] FAIL midframe_extra: got %0d extra pulses, want 0", obsQ.size());
            obsQ.delete();
        end
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        test_reset();
        test_good_frame();
        test_start_glitch();
        test_parity();
        test_framing_break();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
